wb_host_seq: RTL and testbench
==============================

WB_HOST_SEQ -- requirements
Module: wb_host_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles per beat waiting for ack before abort (legal range 1-65535).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the command is accepted when cmd_valid and cmd_ready are both 1.
REQ-006 SHALL have port cmd_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_wide, input, 1 bit: 1 = 64-bit access issued as two 32-bit beats, 0 = single 32-bit beat.
REQ-008 SHALL have port cmd_addr, input, 32 bits: byte address.
REQ-009 SHALL have port cmd_wdata, input, 64 bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the response is consumed when rsp_valid and rsp_ready are both 1.
REQ-012 SHALL have port rsp_rdata, output, 64 bits: read data.
REQ-013 SHALL have port rsp_err, output, 1 bit: the transaction timed out.
REQ-014 SHALL have the Wishbone master outputs wbs_cyc_o, wbs_stb_o and wbs_we_o (1 bit each), wbs_sel_o (4 bits), wbs_adr_o (32 bits) and wbs_dat_o (32 bits).
REQ-015 SHALL have the Wishbone master inputs wbs_ack_i (1 bit) and wbs_dat_i (32 bits).
REQ-016 SHALL have port busy, output, 1 bit: 1 whenever the FSM is not IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, BEAT0, GAP, BEAT1 and RESP.
REQ-018 SHALL assert cmd_ready only in IDLE, and on accept SHALL register all cmd_* fields and enter BEAT0.
REQ-019 In BEAT0 and BEAT1, SHALL hold wbs_cyc_o=1, wbs_stb_o=1, wbs_sel_o=4'hF and wbs_we_o=the registered cmd_we.
REQ-020 In BEAT0, SHALL drive wbs_adr_o = {addr[31:3], addr[2] & ~wide, 2'b00}.
REQ-021 In BEAT1, SHALL drive wbs_adr_o = {addr[31:3], 3'b100}.
REQ-022 SHALL drive wbs_dat_o = wdata[31:0] in BEAT0 and wdata[63:32] in BEAT1; in all other states wbs_dat_o SHALL be 0.
REQ-023 SHALL treat a beat as complete on the first rising edge at which wbs_ack_i=1 while stb=1; an ack at any other time SHALL be ignored.
REQ-024 On a read, SHALL capture wbs_dat_i on beat completion: BEAT0 into rdata[31:0], BEAT1 into rdata[63:32]; on a narrow read rdata[63:32] SHALL be 0.
REQ-025 On BEAT0 completion: wide goes to GAP; narrow goes to RESP.
REQ-026 GAP SHALL last exactly 1 cycle with stb=0 and cyc=1, then go to BEAT1.
REQ-027 On BEAT1 completion, SHALL go to RESP; cyc and stb SHALL be 0 in the cycle after the final ack.
REQ-028 SHALL use a per-beat counter cleared on entry to BEAT0 and BEAT1.
REQ-029 If the counter reaches TIMEOUT_CYCLES with no ack, SHALL drop cyc and stb on the next cycle, set rsp_err=1, force rdata=0 and go to RESP.
REQ-030 In RESP, SHALL hold rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE.
REQ-031 Write transactions SHALL also produce a response, with rsp_rdata=0.
REQ-032 SHALL not accept a new command in the same cycle a response is consumed.
REQ-033 Latency: with ack in the first stb cycle, a narrow transaction SHALL run accept T, stb at T+1, rsp_valid at T+2; a wide transaction SHALL run stb at T+1 and T+3, rsp_valid at T+4.

Reset
REQ-034 While rst_n=0, and immediately on its assertion at any point including mid-beat, SHALL force: state IDLE, cyc/stb/we/rsp_valid/rsp_err/busy=0, wbs_adr_o/wbs_dat_o/rsp_rdata=0, wbs_sel_o=0, counter=0.
REQ-035 cmd_ready SHALL be 0 while rst_n=0 and SHALL equal 1 from the first rising edge after deassertion.
REQ-036 A transaction interrupted by reset SHALL produce no response.

Verification
REQ-037 Narrow write of 0x0000_0001 to 0x3000_0004 with ack after 2 cycles -> one beat, adr 0x3000_0004, dat 0x0000_0001, we=1; then rsp_valid with rsp_rdata=0 and rsp_err=0.
REQ-038 Wide read at 0x3001_0008, slave returning 0xDEAD_BEEF then 0x0000_1010 -> adr 0x3001_0008 then 0x3001_000C, one stb-low GAP cycle between beats, cyc high throughout, rsp_rdata=0x0000_1010_DEAD_BEEF.
REQ-039 Wide write of 0xFEDCBA98_76543210 to 0x3002_0018 -> beats (0x3002_0018, 0x76543210) then (0x3002_001C, 0xFEDCBA98).
REQ-040 Read with no ack, TIMEOUT_CYCLES=4 -> stb high for 4 cycles then dropped, rsp_err=1, rsp_rdata=0.
REQ-041 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, a new cmd_valid is not accepted.
REQ-042 rst_n pulsed low during BEAT1 of a wide read -> cyc/stb drop asynchronously, no rsp_valid, and a following command completes normally.

Source files
------------

// File: rtl/wb_host_seq.sv
// Command-to-Wishbone sequencer: one 32-bit beat, or two beats with a one-cycle
// stb-low gap for 64-bit accesses, with a per-beat ack timeout and a held response.
module wb_host_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_wide,
  input  logic [31:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, BEAT0, GAP, BEAT1, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic        wide;
    logic [31:2] addr;
    logic [63:0] wdata;
  } cmd_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  cmd_t        cmd_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [15:0] cnt;
  logic        rdy_en;
  logic        accept, in_beat, beat_done, tmo;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];

  // rdy_en keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = (state == IDLE) & rdy_en;
  assign accept    = cmd_valid & cmd_ready;
  assign in_beat   = (state == BEAT0) | (state == BEAT1);
  assign beat_done = in_beat & wbs_ack_i;
  assign tmo       = in_beat & ~wbs_ack_i & (cnt == TMO_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = BEAT0;
      BEAT0: if (beat_done)  state_n = cmd_q.wide ? GAP : RESP;
             else if (tmo)   state_n = RESP;
      GAP:   state_n = BEAT1;
      BEAT1: if (beat_done || tmo) state_n = RESP;
      RESP:  if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdy_en  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        cmd_q   <= '{we: cmd_we, wide: cmd_wide, addr: cmd_addr[31:2], wdata: cmd_wdata};
        rdata_q <= '0;
        err_q   <= 1'b0;
        cnt     <= '0;
      end else if (state == GAP) begin
        cnt <= '0;
      end else if (in_beat) begin
        if (beat_done) begin
          if (!cmd_q.we) begin
            if (state == BEAT0) rdata_q <= {32'h0, wbs_dat_i};
            else                rdata_q[63:32] <= wbs_dat_i;
          end
        end else if (tmo) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

  // Bus outputs decode from state only, so an async reset clears them at once
  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = 4'h0;
    wbs_adr_o = 32'h0;
    wbs_dat_o = 32'h0;
    rsp_valid = 1'b0;
    rsp_rdata = 64'h0;
    rsp_err   = 1'b0;
    case (state)
      BEAT0: begin
        wbs_cyc_o = 1'b1;
        wbs_stb_o = 1'b1;
        wbs_we_o  = cmd_q.we;
        wbs_sel_o = 4'hF;
        wbs_adr_o = {cmd_q.addr[31:3], cmd_q.addr[2] & ~cmd_q.wide, 2'b00};
        wbs_dat_o = cmd_q.wdata[31:0];
      end
      GAP: wbs_cyc_o = 1'b1;
      BEAT1: begin
        wbs_cyc_o = 1'b1;
        wbs_stb_o = 1'b1;
        wbs_we_o  = cmd_q.we;
        wbs_sel_o = 4'hF;
        wbs_adr_o = {cmd_q.addr[31:3], 3'b100};
        wbs_dat_o = cmd_q.wdata[63:32];
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_host_seq.sv
// Scoreboarded bench for wb_host_seq: stimulus queues expected beats/responses,
// a monitor pops and compares on each acked beat and each response handshake.
module tb_wb_host_seq;

  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_wide;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic        wbs_ack_i = 1'b0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        busy;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_host_seq #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_wide(cmd_wide),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
    .busy(busy)
  );

  typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; } beat_t;
  typedef struct { logic [63:0] rdata; logic err; } rsp_t;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_delay = 0;
  int          acks_left = -1;
  int          wcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [31:0] d, input logic we);
    beat_t b;
    b.adr = a; b.dat = d; b.we = we;
    beat_q.push_back(b);
  endtask

  task automatic exp_rsp(input logic [63:0] d, input logic e);
    rsp_t r;
    r.rdata = d; r.err = e;
    rsp_q.push_back(r);
  endtask

  // Slave: ack after ack_delay wait cycles; acks_left limits how many beats get acked
  always @(posedge wb_clk_i) begin
    #1;
    wbs_ack_i = 1'b0;
    wbs_dat_i = 32'h0;
    if (wbs_cyc_o && wbs_stb_o) begin
      if (acks_left != 0 && wcnt == ack_delay) begin
        wbs_ack_i = 1'b1;
        wbs_dat_i = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
        if (acks_left > 0) acks_left--;
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge wb_clk_i) begin
    if (rst_n) begin
      if (wbs_cyc_o && wbs_stb_o && wbs_ack_i) begin
        if (beat_q.size() == 0) fail("beat_unexpected");
        else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_adr", 64'(wbs_adr_o), 64'(b.adr));
          chk("beat_dat", 64'(wbs_dat_o), 64'(b.dat));
          chk("beat_we",  64'(wbs_we_o),  64'(b.we));
          chk("beat_sel", 64'(wbs_sel_o), 64'hF);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected");
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", 64'(rsp_err), 64'(r.err));
        end
      end
    end
  end

  task automatic send(input logic we, input logic wide, input logic [31:0] a, input logic [63:0] d);
    int k = 0;
    @(negedge wb_clk_i);
    cmd_we = we; cmd_wide = wide; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && k < 100) begin
      @(negedge wb_clk_i);
      k++;
    end
    if (!cmd_ready) fail("send_accept");
    @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge wb_clk_i);
    while (busy && k < 200) begin
      @(negedge wb_clk_i);
      k++;
    end
    if (busy) fail("wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    rst_n = 1'b0; rsp_ready = 1'b1; cmd_valid = 1'b0;
    cmd_we = 1'b0; cmd_wide = 1'b0; cmd_addr = 32'h0; cmd_wdata = 64'h0;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    chk("rst_cyc_stb", 64'({wbs_cyc_o, wbs_stb_o, wbs_we_o}), 64'h0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, busy}), 64'h0);
    chk("rst_adr_dat_sel", {wbs_adr_o ^ wbs_dat_o, 28'h0, wbs_sel_o}, 64'h0);
    chk("rst_rdata", rsp_rdata, 64'h0);
    rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("rst_release_ready", 64'(cmd_ready), 64'h1);

    // Narrow write, ack after 2 wait cycles
    ack_delay = 2;
    exp_beat(32'h3000_0004, 32'h0000_0001, 1'b1);
    exp_rsp(64'h0, 1'b0);
    send(1'b1, 1'b0, 32'h3000_0004, 64'h0000_0001);
    wait_idle();

    // Wide read, immediate ack: cycle-by-cycle shape
    ack_delay = 0;
    rd_q.push_back(32'hDEAD_BEEF); rd_q.push_back(32'h0000_1010);
    exp_beat(32'h3001_0008, 32'h0, 1'b0);
    exp_beat(32'h3001_000C, 32'h0, 1'b0);
    exp_rsp(64'h0000_1010_DEAD_BEEF, 1'b0);
    send(1'b0, 1'b1, 32'h3001_0008, 64'h0);
    @(negedge wb_clk_i);
    chk("wide_t1_cyc_stb", 64'({wbs_cyc_o, wbs_stb_o}), 64'h3);
    @(negedge wb_clk_i);
    chk("wide_gap_cyc_stb", 64'({wbs_cyc_o, wbs_stb_o}), 64'h2);
    chk("wide_gap_dat", 64'(wbs_dat_o), 64'h0);
    @(negedge wb_clk_i);
    chk("wide_t3_cyc_stb", 64'({wbs_cyc_o, wbs_stb_o}), 64'h3);
    @(negedge wb_clk_i);
    chk("wide_t4_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("wide_t4_cyc_stb", 64'({wbs_cyc_o, wbs_stb_o}), 64'h0);
    wait_idle();

    // Wide write, ack after 1 wait cycle
    ack_delay = 1;
    exp_beat(32'h3002_0018, 32'h7654_3210, 1'b1);
    exp_beat(32'h3002_001C, 32'hFEDC_BA98, 1'b1);
    exp_rsp(64'h0, 1'b0);
    send(1'b1, 1'b1, 32'h3002_0018, 64'hFEDC_BA98_7654_3210);
    wait_idle();

    // Narrow read latency with addr[2]=1 kept
    ack_delay = 0;
    rd_q.push_back(32'h1234_5678);
    exp_beat(32'h4000_000C, 32'h0, 1'b0);
    exp_rsp(64'h0000_0000_1234_5678, 1'b0);
    send(1'b0, 1'b0, 32'h4000_000C, 64'h0);
    @(negedge wb_clk_i);
    chk("narrow_t1_stb", 64'(wbs_stb_o), 64'h1);
    @(negedge wb_clk_i);
    chk("narrow_t2_rsp_valid", 64'(rsp_valid), 64'h1);
    wait_idle();

    // Wide access with addr[2]=1: first beat aligns down
    ack_delay = 1;
    rd_q.push_back(32'h1111_1111); rd_q.push_back(32'h2222_2222);
    exp_beat(32'h5000_0000, 32'h0, 1'b0);
    exp_beat(32'h5000_0004, 32'h0, 1'b0);
    exp_rsp(64'h2222_2222_1111_1111, 1'b0);
    send(1'b0, 1'b1, 32'h5000_0004, 64'h0);
    wait_idle();

    // Ack on the last allowed cycle still completes
    ack_delay = 3;
    rd_q.push_back(32'h0BAD_F00D);
    exp_beat(32'h5000_0100, 32'h0, 1'b0);
    exp_rsp(64'h0000_0000_0BAD_F00D, 1'b0);
    send(1'b0, 1'b0, 32'h5000_0100, 64'h0);
    wait_idle();

    // Narrow timeout: stb held exactly 4 cycles
    ack_delay = 0; acks_left = 0;
    exp_rsp(64'h0, 1'b1);
    send(1'b0, 1'b0, 32'h6000_0000, 64'h0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge wb_clk_i);
      if (wbs_stb_o) n++;
    end
    chk("tmo_narrow_stb_cycles", 64'(n), 64'd4);
    wait_idle();

    // Wide timeout on beat 1 discards beat-0 data
    acks_left = 1;
    rd_q.push_back(32'hCAFE_0000);
    exp_beat(32'h6000_0010, 32'h0, 1'b0);
    exp_rsp(64'h0, 1'b1);
    send(1'b0, 1'b1, 32'h6000_0010, 64'h0);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge wb_clk_i);
      if (wbs_stb_o) n++;
    end
    chk("tmo_wide_stb_cycles", 64'(n), 64'd5);
    wait_idle();
    acks_left = -1;

    // Response backpressure, then a pending command accepted only after release
    @(posedge wb_clk_i); #1 rsp_ready = 1'b0;
    rd_q.push_back(32'hA5A5_0001);
    exp_beat(32'h7000_0000, 32'h0, 1'b0);
    exp_rsp(64'h0000_0000_A5A5_0001, 1'b0);
    exp_beat(32'h7000_0010, 32'h0000_0055, 1'b1);
    exp_rsp(64'h0, 1'b0);
    send(1'b0, 1'b0, 32'h7000_0000, 64'h0);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge wb_clk_i);
      k++;
    end
    if (!rsp_valid) fail("bp_rsp_valid");
    cmd_we = 1'b1; cmd_wide = 1'b0; cmd_addr = 32'h7000_0010; cmd_wdata = 64'h55; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid_hold", 64'(rsp_valid), 64'h1);
      chk("bp_rdata_hold", rsp_rdata, 64'h0000_0000_A5A5_0001);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'h0);
      @(negedge wb_clk_i);
    end
    @(posedge wb_clk_i); #1 rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("bp_after_release_idle", 64'({cmd_ready, rsp_valid, busy}), 64'h4);
    @(posedge wb_clk_i); #1 cmd_valid = 1'b0;
    wait_idle();

    // Reset pulse during beat 1 of a wide read
    ack_delay = 2;
    rd_q.push_back(32'h9999_0000);
    exp_beat(32'h8000_0000, 32'h0, 1'b0);
    send(1'b0, 1'b1, 32'h8000_0000, 64'h0);
    k = 0;
    @(negedge wb_clk_i);
    while (!(wbs_stb_o && wbs_adr_o[2]) && k < 50) begin
      @(negedge wb_clk_i);
      k++;
    end
    if (!(wbs_stb_o && wbs_adr_o[2])) fail("rst_beat1_reach");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_stb", 64'({wbs_cyc_o, wbs_stb_o, busy}), 64'h0);
    chk("rst_mid_adr", 64'(wbs_adr_o), 64'h0);
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      if (rsp_valid) n++;
    end
    chk("rst_mid_no_rsp", 64'(n), 64'h0);
    ack_delay = 0;
    exp_beat(32'h8000_0020, 32'h0000_ABCD, 1'b1);
    exp_rsp(64'h0, 1'b0);
    send(1'b1, 1'b0, 32'h8000_0020, 64'hABCD);
    wait_idle();

    repeat (2) @(negedge wb_clk_i);
    chk("beat_q_drained", 64'(beat_q.size()), 64'h0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'h0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
